// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer
//
// Oversamples an asynchronous I2S stream (BCLK, LRCK, SDATA) in the CLOCK_50
// domain and turns each complete stereo frame into a pair of parallel signed
// words. A one-cycle sample_valid strobe marks the cycle in which both
// sample outputs change together.
//
// Parameters:
//   SAMPLE_WIDTH  bits kept per channel slot, MSB first
//   SYNC_STAGES   synchronizer depth on each I2S input (2 or more)
//
// Ports:
//   CLOCK_50              in   system clock
//   RESET                 in   synchronous, active-high reset
//   i2s_bit_clock         in   asynchronous BCLK
//   i2s_left_right_select in   asynchronous LRCK (0 = left, 1 = right)
//   i2s_sound_data        in   asynchronous serial data
//   sample_left           out  last complete left word
//   sample_right          out  last complete right word
//   sample_valid          out  one-cycle pulse, both words updated
//   frame_error           out  sticky short-slot flag
//
// Optional feature: define I2S_RX_FRAME_CHECK_EN to enable the sticky
// short-slot detector on frame_error; otherwise frame_error is tied low.
module i2s_rx_deserializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    i2s_bit_clock,
  input  logic                    i2s_left_right_select,
  input  logic                    i2s_sound_data,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic                    frame_error
);

  localparam int            CW   = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(SAMPLE_WIDTH);

  typedef enum logic {
    ALIGN,
    CAPTURE
  } state_t;

  logic [SYNC_STAGES-1:0]  bclk_sync_q;
  logic [SYNC_STAGES-1:0]  lrck_sync_q;
  logic [SYNC_STAGES-1:0]  data_sync_q;
  logic                    bclk_prev_q;
  logic                    rise_q;
  logic                    lrck_q;
  logic                    data_q;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_d;
  logic [SAMPLE_WIDTH-1:0] sh_q;
  logic [SAMPLE_WIDTH-1:0] sh_d;
  logic [SAMPLE_WIDTH-1:0] staging_q;
  logic                    lrck_last_q;
  logic                    lrck_seen_q;
  logic                    left_ok_q;
  logic [SAMPLE_WIDTH-1:0] sample_left_q;
  logic [SAMPLE_WIDTH-1:0] sample_right_q;
  logic                    sample_valid_q;

  logic                    boundary;
  logic                    slot_full;

  // Plain shift-register synchronizers, one per asynchronous input.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bit_clock};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_left_right_select};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i2s_sound_data};
    end
  end

  // BCLK rising-edge detect. The edge flag is registered together with the
  // LRCK and data bits seen at that edge, so the capture logic below works
  // from one consistent snapshot.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      bclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      lrck_q      <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
      rise_q      <= bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
      lrck_q      <= lrck_sync_q[SYNC_STAGES-1];
      data_q      <= data_sync_q[SYNC_STAGES-1];
    end
  end

  // Post-shift view of the slot. A saturated counter means the slot is
  // longer than the word, so further bits are ignored.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (cnt_q < FULL) begin
      sh_d  = {sh_q[SAMPLE_WIDTH-2:0], data_q};
      cnt_d = cnt_q + CW'(1);
    end
  end

  // The very first edge after reset has no earlier LRCK to compare against,
  // so it only records the channel and is never treated as a boundary.
  assign boundary  = lrck_seen_q && (lrck_q != lrck_last_q);
  assign slot_full = (cnt_d == FULL);

  // Slot capture state machine. On a boundary the bit just shifted in is the
  // LSB of the slot that is ending; lrck_last_q still names that slot's
  // channel. Left words wait in staging until a matching right word arrives.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q        <= ALIGN;
      cnt_q          <= '0;
      sh_q           <= '0;
      staging_q      <= '0;
      lrck_last_q    <= 1'b0;
      lrck_seen_q    <= 1'b0;
      left_ok_q      <= 1'b0;
      sample_left_q  <= '0;
      sample_right_q <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (rise_q) begin
        lrck_last_q <= lrck_q;
        lrck_seen_q <= 1'b1;
        case (state_q)
          ALIGN: begin
            if (boundary) begin
              state_q <= CAPTURE;
              cnt_q   <= '0;
            end
          end
          CAPTURE: begin
            if (!boundary) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_d;
            end else begin
              cnt_q <= '0;
              if (slot_full) begin
                if (!lrck_last_q) begin
                  staging_q <= sh_d;
                  left_ok_q <= 1'b1;
                end else if (left_ok_q) begin
                  sample_left_q  <= staging_q;
                  sample_right_q <= sh_d;
                  sample_valid_q <= 1'b1;
                  left_ok_q      <= 1'b0;
                end
              end else if (!lrck_last_q) begin
                // A short left slot invalidates the frame it belongs to.
                left_ok_q <= 1'b0;
              end
            end
          end
          default: state_q <= ALIGN;
        endcase
      end
    end
  end

  assign sample_left  = sample_left_q;
  assign sample_right = sample_right_q;
  assign sample_valid = sample_valid_q;

`ifdef I2S_RX_FRAME_CHECK_EN
  logic frame_error_q;

  // Sticky flag: any slot that ends before a full word was collected.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      frame_error_q <= 1'b0;
    end else if (rise_q && (state_q == CAPTURE) && boundary && !slot_full) begin
      frame_error_q <= 1'b1;
    end
  end

  assign frame_error = frame_error_q;
`else
  assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb_i2s_rx_deserializer
//
// Drives I2S slot sequences into i2s_rx_deserializer and checks captured
// frames against constant tables and against a slot-level reference model.
// Honors I2S_RX_FRAME_CHECK_EN when predicting frame_error.
module tb_i2s_rx_deserializer;

  localparam int W    = 16;
  localparam int SYNC = 2;
`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic FERR = 1'b1;
`else
  localparam logic FERR = 1'b0;
`endif

  logic         CLOCK_50 = 1'b0;
  logic         RESET    = 1'b1;
  logic         bclk     = 1'b0;
  logic         lrck     = 1'b0;
  logic         sdata    = 1'b0;
  logic [W-1:0] sample_left;
  logic [W-1:0] sample_right;
  logic         sample_valid;
  logic         frame_error;

  i2s_rx_deserializer #(
    .SAMPLE_WIDTH(W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLOCK_50             (CLOCK_50),
    .RESET                (RESET),
    .i2s_bit_clock        (bclk),
    .i2s_left_right_select(lrck),
    .i2s_sound_data       (sdata),
    .sample_left          (sample_left),
    .sample_right         (sample_right),
    .sample_valid         (sample_valid),
    .frame_error          (frame_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int             tests    = 0;
  int             failures = 0;
  logic [2*W-1:0] obsQ[$];
  logic [2*W-1:0] expQ[$];
  int             obsBase  = 0;
  logic           slotLr[$];
  int             slotLen[$];
  logic [W-1:0]   slotWord[$];
  logic           prevLast = 1'b0;
  logic           lastLr   = 1'b0;
  int             halfCycles = 8;

  typedef struct {
    string        name;
    int           lenL;
    logic [63:0]  dL;
    int           lenR;
    logic [63:0]  dR;
    int           frames;
    logic [W-1:0] expL;
    logic [W-1:0] expR;
    int           expPulses;
    logic         expErr;
  } vec_t;

  vec_t vecs[5];

  // Record every strobe, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (sample_valid) obsQ.push_back({sample_left, sample_right});
  end

  initial begin
    #(90000 * 20);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One BCLK period: data and LRCK change while BCLK is low.
  task automatic sendBit(input logic lr, input logic d);
    bclk  = 1'b0;
    lrck  = lr;
    sdata = d;
    repeat (halfCycles) @(negedge CLOCK_50);
    bclk = 1'b1;
    repeat (halfCycles) @(negedge CLOCK_50);
  endtask

  // A slot of len BCLKs; d holds the slot bits MSB-aligned. The first BCLK
  // carries the last bit of the previous slot (I2S one-bit delay).
  task automatic sendSlot(input logic lr, input int len, input logic [63:0] d);
    logic b;
    for (int n = 0; n < len; n++) begin
      b = (n == 0) ? prevLast : d[64-n];
      sendBit(lr, b);
    end
    prevLast = d[64-len];
    lastLr   = lr;
    slotLr.push_back(lr);
    slotLen.push_back(len);
    slotWord.push_back(d[63 -: W]);
  endtask

  // Delivers the final LSB so the last slot sees its boundary, then idles.
  task automatic closeStream();
    sendBit(~lastLr, prevLast);
    bclk = 1'b0;
    repeat (12) @(negedge CLOCK_50);
  endtask

  task automatic doReset(input bit toggle);
    RESET = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (toggle) begin
        bclk  = 1'($urandom);
        lrck  = 1'($urandom);
        sdata = 1'($urandom);
      end else begin
        bclk = 1'b0;
      end
      @(negedge CLOCK_50);
    end
    bclk  = 1'b0;
    lrck  = 1'b0;
    sdata = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checkOutput("reset_outputs", {sample_left, sample_right, sample_valid, frame_error}, 64'h0);
    RESET = 1'b0;
    obsBase  = obsQ.size();
    prevLast = 1'b0;
    slotLr.delete();
    slotLen.delete();
    slotWord.delete();
  endtask

  // Reference model: slot 0 only aligns; every later slot holding at least W
  // bits yields its first W bits; a frame is a valid left slot immediately
  // followed by a valid right slot.
  task automatic buildModel(output logic expErr);
    expQ.delete();
    expErr = 1'b0;
    for (int i = 1; i < slotLen.size(); i++) begin
      if (slotLen[i] < W) expErr = FERR;
      if (i >= 2 && slotLr[i] && !slotLr[i-1] && slotLen[i] >= W && slotLen[i-1] >= W)
        expQ.push_back({slotWord[i-1], slotWord[i]});
    end
  endtask

  task automatic runCheck(input string name);
    logic           expErr;
    logic [2*W-1:0] lastPair;
    int             got;
    buildModel(expErr);
    got = obsQ.size() - obsBase;
    checkOutput({name, "_count"}, 64'(got), 64'(expQ.size()));
    for (int i = 0; i < got && i < expQ.size(); i++)
      checkOutput({name, "_pair"}, 64'(obsQ[obsBase+i]), 64'(expQ[i]));
    lastPair = (expQ.size() > 0) ? expQ[expQ.size()-1] : '0;
    checkOutput({name, "_hold"}, 64'({sample_left, sample_right}), 64'(lastPair));
    checkOutput({name, "_ferr"}, 64'(frame_error), 64'(expErr));
  endtask

  task automatic applyStimulus(input vec_t v);
    doReset(1'b0);
    halfCycles = 8;
    sendSlot(1'b1, 5, 64'hB800_0000_0000_0000);
    for (int f = 0; f < v.frames; f++) begin
      sendSlot(1'b0, v.lenL, v.dL);
      sendSlot(1'b1, v.lenR, v.dR);
    end
    closeStream();
  endtask

  initial begin
    int got;
    int lat;
    vecs[0] = '{"std16", 16, 64'hA5C3_0000_0000_0000, 16, 64'h1234_0000_0000_0000,
                3, 16'hA5C3, 16'h1234, 3, 1'b0};
    vecs[1] = '{"long32", 32, 64'h8001_FFFF_0000_0000, 32, 64'h7FFE_0000_0000_0000,
                2, 16'h8001, 16'h7FFE, 2, 1'b0};
    vecs[2] = '{"extremes", 16, 64'hFFFF_0000_0000_0000, 16, 64'h0000_0000_0000_0000,
                2, 16'hFFFF, 16'h0000, 2, 1'b0};
    vecs[3] = '{"odd_len", 17, 64'h8000_8000_0000_0000, 24, 64'h0001_FF00_0000_0000,
                2, 16'h8000, 16'h0001, 2, 1'b0};
    vecs[4] = '{"short_both", 12, 64'hABC0_0000_0000_0000, 12, 64'h1230_0000_0000_0000,
                2, 16'h0000, 16'h0000, 0, FERR};

    repeat (2) @(negedge CLOCK_50);

    // Table-driven frames.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      got = obsQ.size() - obsBase;
      checkOutput({vecs[k].name, "_count"}, 64'(got), 64'(vecs[k].expPulses));
      for (int i = 0; i < got; i++)
        checkOutput({vecs[k].name, "_pair"}, 64'(obsQ[obsBase+i]), 64'({vecs[k].expL, vecs[k].expR}));
      checkOutput({vecs[k].name, "_hold"}, 64'({sample_left, sample_right}),
                  (vecs[k].expPulses > 0) ? 64'({vecs[k].expL, vecs[k].expR}) : 64'h0);
      checkOutput({vecs[k].name, "_ferr"}, 64'(frame_error), 64'(vecs[k].expErr));
    end

    // Reset with toggling inputs, then no strobe until a full frame.
    doReset(1'b1);
    halfCycles = 8;
    sendSlot(1'b1, 6, 64'h5400_0000_0000_0000);
    sendSlot(1'b0, 16, 64'hCAFE_0000_0000_0000);
    checkOutput("no_early_pulse_a", 64'(obsQ.size() - obsBase), 64'h0);
    sendSlot(1'b1, 16, 64'h0BAD_0000_0000_0000);
    checkOutput("no_early_pulse_b", 64'(obsQ.size() - obsBase), 64'h0);
    closeStream();
    runCheck("after_reset");
    checkOutput("after_reset_val", 64'({sample_left, sample_right}), 64'hCAFE_0BAD);

    // Short left slot drops its frame; the next frame is normal.
    doReset(1'b0);
    sendSlot(1'b1, 5, 64'h7000_0000_0000_0000);
    sendSlot(1'b0, 16, 64'hA5C3_0000_0000_0000);
    sendSlot(1'b1, 16, 64'h1234_0000_0000_0000);
    sendSlot(1'b0, 12, 64'hFFF0_0000_0000_0000);
    sendSlot(1'b1, 16, 64'h5555_0000_0000_0000);
    sendSlot(1'b0, 16, 64'h1111_0000_0000_0000);
    sendSlot(1'b1, 16, 64'h2222_0000_0000_0000);
    closeStream();
    runCheck("short_left");
    checkOutput("short_left_ferr", 64'(frame_error), 64'(FERR));
    checkOutput("short_left_last", 64'({sample_left, sample_right}), 64'h1111_2222);

    // RESET in the middle of a left slot.
    doReset(1'b0);
    sendSlot(1'b1, 5, 64'h2800_0000_0000_0000);
    sendSlot(1'b0, 16, 64'hA5C3_0000_0000_0000);
    sendSlot(1'b1, 16, 64'h1234_0000_0000_0000);
    sendSlot(1'b0, 7, 64'h5A00_0000_0000_0000);
    checkOutput("rst_mid_prepulse", 64'(obsQ.size() - obsBase), 64'h1);
    doReset(1'b0);
    sendSlot(1'b0, 9, 64'h5A00_0000_0000_0000);
    sendSlot(1'b1, 16, 64'hBEEF_0000_0000_0000);
    sendSlot(1'b0, 16, 64'h0F0F_0000_0000_0000);
    sendSlot(1'b1, 16, 64'hF0F0_0000_0000_0000);
    closeStream();
    runCheck("rst_mid");
    checkOutput("rst_mid_val", 64'({sample_left, sample_right}), 64'h0F0F_F0F0);

    // Strobe latency from BCLK going high at the pin for the closing edge.
    doReset(1'b0);
    sendSlot(1'b1, 3, 64'h6000_0000_0000_0000);
    sendSlot(1'b0, 16, 64'h1357_0000_0000_0000);
    sendSlot(1'b1, 16, 64'h2468_0000_0000_0000);
    bclk  = 1'b0;
    lrck  = 1'b0;
    sdata = prevLast;
    repeat (halfCycles) @(negedge CLOCK_50);
    bclk = 1'b1;
    lat  = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLOCK_50);
      if (sample_valid && lat < 0) lat = c;
    end
    bclk = 1'b0;
    repeat (12) @(negedge CLOCK_50);
    checkOutput("valid_latency", 64'(lat), 64'(SYNC + 2));
    runCheck("latency");

    // Randomized slot streams at varied BCLK rates.
    for (int r = 0; r < 6; r++) begin
      int lens[8] = '{12, 15, 16, 16, 16, 17, 24, 32};
      int nSlots;
      doReset(1'b0);
      halfCycles = int'($urandom_range(2, 5));
      sendSlot(1'b1, int'($urandom_range(1, 10)), {$urandom, $urandom});
      nSlots = int'($urandom_range(8, 12));
      for (int s = 0; s < nSlots; s++)
        sendSlot(1'(s % 2), lens[$urandom_range(0, 7)], {$urandom, $urandom});
      closeStream();
      runCheck("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
